// File: rtl/ifu_fetch_q.sv
// ---------------------------------------------------------------------------
// ifu_fetch_q
//
// Instruction fetch unit with a small in-order fetch queue. It generates
// sequential fetch PCs, issues pipelined instruction-memory requests over a
// valid/ready handshake, and buffers the in-order responses (with their PCs)
// until the decode stage takes them. A redirect from the EXU flushes the queue
// and arranges for responses to already-issued stale requests to be dropped.
//
// Optional feature (macro IFU_MISALIGN_CHECK_EN):
//   A redirect to a target with non-zero low two bits produces a single
//   exception entry (excp=1, pc=target, inst=0) without touching memory, and
//   fetching stays blocked until the next redirect. Without the macro the
//   check is absent, o_ifu_excp is tied low and such targets are fetched
//   normally.
//
// Ports:
//   i_sys_clk        clock
//   i_sys_rst        asynchronous active-high reset
//   i_exu_jmp_en     single-cycle redirect strobe
//   i_exu_jmp_pc     redirect target
//   i_ifu_stall      suppresses new memory requests only
//   o_mem_req_valid  memory request valid (independent of ready)
//   i_mem_req_ready  memory accepts request
//   o_mem_req_addr   request address (current fetch PC)
//   i_mem_rsp_valid  in-order response, one per accepted request
//   i_mem_rsp_data   response instruction word
//   o_ifu_valid      queue head holds a filled entry
//   i_idu_ready      decode accepts the head
//   o_ifu_pc         head PC
//   o_ifu_inst       head instruction
//   o_ifu_excp       head is a misaligned-target entry
// ---------------------------------------------------------------------------
module ifu_fetch_q #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = 32'h8000_0000,
  parameter int                    PC_STEP    = 4,
  parameter int                    FQ_DEPTH   = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  input  logic                  i_ifu_stall,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_ifu_valid,
  input  logic                  i_idu_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  output logic                  o_ifu_excp
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [PW+1:0]       DEPTH_OCC = FQ_DEPTH[PW+1:0];
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);

  // Pointers carry one extra wrap bit so that full and empty differ.
  typedef logic [PW:0] ptr_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  ptr_t                  alloc_q, alloc_d;
  ptr_t                  fill_q, fill_d;
  ptr_t                  rd_q, rd_d;
  ptr_t                  kill_q, kill_d;

  logic [ADDR_WIDTH-1:0] ent_pc_q   [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0] ent_pc_d   [FQ_DEPTH];
  logic [INST_WIDTH-1:0] ent_inst_q [FQ_DEPTH];
  logic [INST_WIDTH-1:0] ent_inst_d [FQ_DEPTH];

`ifdef IFU_MISALIGN_CHECK_EN
  logic                  ent_excp_q [FQ_DEPTH];
  logic                  ent_excp_d [FQ_DEPTH];
  logic                  blk_q, blk_d;
  logic                  jmp_misaligned;
`endif

  ptr_t                  allocated;
  ptr_t                  unfilled;
  logic [PW+1:0]         occupancy;
  logic                  req_block;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  deq;
  logic [PW-1:0]         alloc_idx;
  logic [PW-1:0]         fill_idx;
  logic [PW-1:0]         rd_idx;

  assign allocated = alloc_q - rd_q;
  assign unfilled  = alloc_q - fill_q;

  // Stale requests still owed a response consume queue credit, so a fresh
  // stream after a redirect cannot outrun the responses that will be dropped.
  assign occupancy = {1'b0, allocated} + {1'b0, kill_q};

  assign alloc_idx = alloc_q[PW-1:0];
  assign fill_idx  = fill_q[PW-1:0];
  assign rd_idx    = rd_q[PW-1:0];

`ifdef IFU_MISALIGN_CHECK_EN
  assign req_block      = blk_q;
  assign jmp_misaligned = (i_exu_jmp_pc[1:0] != 2'b00);
`else
  assign req_block      = 1'b0;
`endif

  // Reset gating keeps the request line quiet while the memory side is also
  // held in reset.
  assign o_mem_req_valid = !i_sys_rst && !i_ifu_stall && !req_block &&
                           (occupancy < DEPTH_OCC);
  assign o_mem_req_addr  = pc_q;

  assign req_fire = o_mem_req_valid && i_mem_req_ready;
  assign rsp_fire = i_mem_rsp_valid;

  assign o_ifu_valid = (fill_q != rd_q);
  assign o_ifu_pc    = ent_pc_q[rd_idx];
  assign o_ifu_inst  = ent_inst_q[rd_idx];
  assign deq         = o_ifu_valid && i_idu_ready;

`ifdef IFU_MISALIGN_CHECK_EN
  assign o_ifu_excp  = ent_excp_q[rd_idx];
`else
  assign o_ifu_excp  = 1'b0;
`endif

  // Next-state logic. A redirect overrides every other same-cycle event:
  // pointers restart at zero and everything still outstanding at memory
  // (unfilled entries plus a request accepted this cycle, less a response
  // consumed this cycle) is added to the kill count.
  always_comb begin
    pc_d       = pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    kill_d     = kill_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;
`ifdef IFU_MISALIGN_CHECK_EN
    ent_excp_d = ent_excp_q;
    blk_d      = blk_q;
`endif

    if (i_exu_jmp_en) begin
      pc_d    = i_exu_jmp_pc;
      alloc_d = '0;
      fill_d  = '0;
      rd_d    = '0;
      kill_d  = kill_q + unfilled + ptr_t'(req_fire) - ptr_t'(rsp_fire);
`ifdef IFU_MISALIGN_CHECK_EN
      blk_d = 1'b0;
      if (jmp_misaligned) begin
        // Exception entry is born filled; fetch stays parked until the EXU
        // redirects again.
        ent_pc_d[0]   = i_exu_jmp_pc;
        ent_inst_d[0] = '0;
        ent_excp_d[0] = 1'b1;
        alloc_d       = ptr_t'(1);
        fill_d        = ptr_t'(1);
        blk_d         = 1'b1;
      end
`endif
    end else begin
      if (req_fire) begin
        ent_pc_d[alloc_idx] = pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
        ent_excp_d[alloc_idx] = 1'b0;
`endif
        alloc_d = alloc_q + ptr_t'(1);
        pc_d    = pc_q + STEP;
      end

      // Responses are in order, so the oldest outstanding requests are the
      // stale ones: drop while the kill count is non-zero.
      if (rsp_fire) begin
        if (kill_q != '0) begin
          kill_d = kill_q - ptr_t'(1);
        end else begin
          ent_inst_d[fill_idx] = i_mem_rsp_data;
          fill_d               = fill_q + ptr_t'(1);
        end
      end

      if (deq) begin
        rd_d = rd_q + ptr_t'(1);
      end
    end
  end

  // State registers. Entry storage is cleared too so that the head fields
  // read as zero out of reset.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      pc_q       <= ADDR_INIT;
      alloc_q    <= '0;
      fill_q     <= '0;
      rd_q       <= '0;
      kill_q     <= '0;
      ent_pc_q   <= '{default: '0};
      ent_inst_q <= '{default: '0};
`ifdef IFU_MISALIGN_CHECK_EN
      ent_excp_q <= '{default: 1'b0};
      blk_q      <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
      kill_q     <= kill_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
      ent_excp_q <= ent_excp_d;
      blk_q      <= blk_d;
`endif
    end
  end

endmodule

// File: doc/ifu_fetch_q.md
Name: ifu_fetch_q

Overview:
- Parametrised successor to the single-register IFU PC stage.
- Sits between the PC/redirect source (EXU) and the decode stage (IDU).
- Generates sequential fetch addresses and issues pipelined instruction-memory requests with a valid/ready handshake.
- Buffers in-order responses, with their PCs, in a FQ_DEPTH-entry fetch queue. On a redirect it flushes the queue and silently discards responses to in-flight stale requests.

Parameters:
- ADDR_WIDTH, 32, fetch address width.
- INST_WIDTH, 32, instruction word width.
- ADDR_INIT, 32'h8000_0000, PC after reset (ADDR_WIDTH bits).
- PC_STEP, 4, sequential PC increment.
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2.

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst  in  1  asynchronous active-high reset.
- i_exu_jmp_en  in  1  redirect strobe, single cycle.
- i_exu_jmp_pc  in  ADDR_WIDTH  redirect target.
- i_ifu_stall  in  1  1 = suppress new memory requests; queue and responses unaffected.
- o_mem_req_valid  out  1  request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_addr  out  ADDR_WIDTH  request address (= fetch PC).
- i_mem_rsp_valid  in  1  response valid; in order, one per accepted request; no backpressure.
- i_mem_rsp_data  in  INST_WIDTH  response instruction.
- o_ifu_valid  out  1  queue head holds a filled entry.
- i_idu_ready  in  1  decode accepts head.
- o_ifu_pc  out  ADDR_WIDTH  head PC.
- o_ifu_inst  out  INST_WIDTH  head instruction.
- o_ifu_excp  out  1  head is a misaligned-target entry (feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync-released by the flop): r_pc=ADDR_INIT; all pointers, count and kill_cnt = 0. Outputs: o_mem_req_valid=0, o_ifu_valid=0, o_ifu_pc=0, o_ifu_inst=0, o_ifu_excp=0, o_mem_req_addr=ADDR_INIT. Reset mid-operation drops everything; responses arriving after reset release must not occur (memory is reset together).
- Queue state: alloc_ptr, fill_ptr, rd_ptr, each log2(FQ_DEPTH)+1 bits with wrap bit. Allocated = alloc-rd; unfilled = alloc-fill.
- Request issue: o_mem_req_valid = !i_ifu_stall && (allocated + kill_cnt < FQ_DEPTH). Must not depend on i_mem_req_ready.
- req_fire = valid && ready. On req_fire: entry[alloc].pc <= r_pc, alloc++, r_pc <= r_pc + PC_STEP (modulo 2^ADDR_WIDTH wrap).
- Response: if kill_cnt>0, data is dropped and kill_cnt--. Else entry[fill].inst <= data, fill++.
- Output: o_ifu_valid = (fill != rd); o_ifu_pc/o_ifu_inst are the registered head fields. deq = o_ifu_valid && i_idu_ready → rd++.
- Latency: request at cycle N, response at cycle M → o_ifu_valid in cycle M+1 at earliest. Full throughput is 1 instr/cycle with single-cycle memory and FQ_DEPTH≥2.
- Redirect (i_exu_jmp_en=1) has priority over all same-cycle events:
  - r_pc <= i_exu_jmp_pc.
  - alloc, fill, rd <= 0.
  - kill_cnt <= kill_cnt + unfilled + req_fire − rsp_fire.
  - The same-cycle dequeue is suppressed from the IDU view only; the IDU discards it because the EXU redirected.
  - The same-cycle accepted request becomes stale and is killed.
- Invariant: allocated + kill_cnt ≤ FQ_DEPTH; kill_cnt width log2(FQ_DEPTH)+1.
- Full: no request; existing entries drain. Empty: o_ifu_valid=0.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined:
  - A redirect target with i_exu_jmp_pc[1:0]≠0 allocates one entry with excp=1 and pc=target, filled immediately, without a memory request.
  - Further requests are blocked until the next redirect.
  - The head presents o_ifu_valid=1, o_ifu_excp=1, o_ifu_inst=0.
- Undefined: no check; o_ifu_excp tied 0; misaligned targets are fetched as normal.

Test Plan:
- Reset, mem ready=1, 1-cycle response returning addr as data → requests 0x8000_0000, 0x8000_0004, …; IDU ready=1 sees one instruction per cycle, in order, with matching PCs.
- IDU ready=0 → exactly FQ_DEPTH=4 requests issued, then o_mem_req_valid=0. IDU ready=1 → drains 4 entries, requests resume at 0x8000_0010.
- 3-cycle response latency, redirect to 0x8000_0100 with 3 requests in flight → 3 responses dropped, kill_cnt returns to 0, first delivered PC is 0x8000_0100.
- Redirect in the same cycle as req_fire and rsp_fire → kill_cnt accounting correct; no stale instruction is ever delivered.
- i_ifu_stall=1 for 5 cycles → no requests; queued entries still drain; PC unchanged.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x8000_0102 → one head entry with excp=1, pc=0x8000_0102, no memory request. A redirect to 0x8000_0200 resumes normal fetch.
